// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg : shared types and constants for the 8-way round-robin arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/onehot_enc_83.sv
// ---------------------------------------------------------------------------
// onehot_enc_83 : 8->3 one-hot encoder, bit i -> 7-i, non-one-hot -> 0
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module onehot_enc_83 (
  input  logic [7:0] onehot,
  output logic [2:0] idx
);

  logic [2:0] acc;
  logic [3:0] hits;

  always_comb begin
    acc  = 3'd0;
    hits = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) begin
        acc  = acc | 3'(7 - i);
        hits = hits + 4'd1;
      end
    end
    idx = (hits == 4'd1) ? acc : 3'd0;
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8 : round-robin arbiter with hold-until-release and hold limit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int CNTW     = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_idx,
  output logic         grant_valid,
  output logic         timeout
);

  import arb_pkg::*;

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
  localparam logic [N-1:0]    ONE_HOT0  = N'(1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] win, win_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]     grant_nxt;
  logic             grant_valid_nxt;
  logic             timeout_nxt;

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] winner;
  logic             hit_limit;
  logic             rel_normal;

  // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) pick = IDX_W'(i);
    end
  end

  assign winner     = ptr + pick;
  assign hit_limit  = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
  assign rel_normal = done || !req[win];

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    win_nxt         = win;
    cnt_nxt         = cnt;
    grant_nxt       = grant;
    grant_valid_nxt = grant_valid;
    timeout_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        grant_nxt       = '0;
        grant_valid_nxt = 1'b0;
        if (|req) begin
          state_nxt       = ST_GRANT;
          win_nxt         = winner;
          grant_nxt       = ONE_HOT0 << winner;
          grant_valid_nxt = 1'b1;
          cnt_nxt         = '0;
        end
      end
      ST_GRANT: begin
        if (rel_normal || hit_limit) begin
          state_nxt       = ST_IDLE;
          grant_nxt       = '0;
          grant_valid_nxt = 1'b0;
          ptr_nxt         = win + IDX_W'(1);
          cnt_nxt         = '0;
          // A voluntary release on the limit cycle is not a revocation.
          timeout_nxt     = hit_limit && !rel_normal;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      win         <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      win         <= win_nxt;
      cnt         <= cnt_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
      timeout     <= timeout_nxt;
    end
  end

  onehot_enc_83 u_enc (
    .onehot (grant),
    .idx    (grant_idx)
  );

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_8 : scoreboard bench for rr_arbiter_8 (MAX_HOLD = 4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] g;
    logic [2:0] idx;
    int         hold;
    logic       to;
    bit         chk;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter_8 #(.N(8), .CNTW(8), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [7:0] g, input logic [2:0] idx, input int hold,
                      input logic to, input bit chk);
    exp_t e;
    e.g = g; e.idx = idx; e.hold = hold; e.to = to; e.chk = chk;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per new grant, checks hold length and timeout at release.
  initial begin
    exp_t cur;
    int   hold_cnt;
    bit   prev_v;
    prev_v   = 1'b0;
    hold_cnt = 0;
    cur.chk  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        continue;
      end
      if (grant_valid && !prev_v) begin
        hold_cnt = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got grant=0x%0h expected none", grant);
          cur.chk = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("grant", 32'(grant), 32'(cur.g));
          check("grant_idx", 32'(grant_idx), 32'(cur.idx));
        end
      end else if (grant_valid) begin
        hold_cnt++;
      end else if (prev_v) begin
        if (cur.chk) begin
          check("hold_cycles", 32'(hold_cnt), 32'(cur.hold));
          check("timeout_at_release", 32'(timeout), 32'(cur.to));
          check("grant_after_release", 32'(grant), 32'h0);
        end
      end else if (timeout) begin
        checks++;
        errors++;
        $display("FAIL spurious_timeout: got 1 expected 0 at %0t", $time);
      end
      if (grant_valid && timeout) begin
        checks++;
        errors++;
        $display("FAIL timeout_while_valid: got 1 expected 0 at %0t", $time);
      end
      prev_v = grant_valid;
    end
  end

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (grant_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: got no grant expected grant within 20 cycles");
    end
  endtask

  // mode 0: done pulse after h cycles; mode 1: drop bits in mask after h cycles; mode 2: stuck owner
  task automatic serve(input int h, input int mode, input logic [7:0] mask);
    bit ok;
    wait_grant(ok);
    if (!ok) return;
    if (mode == 2) begin
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(posedge clk);
        #1;
        if (!grant_valid) ok = 1'b1;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL wait_release: got grant held expected release within 20 cycles");
      end
    end else begin
      repeat (h - 1) begin
        @(posedge clk);
        #1;
      end
      if (mode == 0) done = 1'b1;
      else           req  = req & ~mask;
      @(posedge clk);
      #1;
      done = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    rst_n = 1'b1;
    req   = 8'hFF;
    done  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_idx", 32'(grant_idx), 32'h0);
    check("reset_valid", 32'(grant_valid), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);

    // Fairness from ptr=0: bits 0..7 then 0 again, holds of 1/2/3 cycles.
    push(8'h01, 3'd7, 1, 1'b0, 1'b1);
    push(8'h02, 3'd6, 2, 1'b0, 1'b1);
    push(8'h04, 3'd5, 3, 1'b0, 1'b1);
    push(8'h08, 3'd4, 1, 1'b0, 1'b1);
    push(8'h10, 3'd3, 2, 1'b0, 1'b1);
    push(8'h20, 3'd2, 3, 1'b0, 1'b1);
    push(8'h40, 3'd1, 1, 1'b0, 1'b1);
    push(8'h80, 3'd0, 2, 1'b0, 1'b1);
    push(8'h01, 3'd7, 3, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) serve((i % 3) + 1, 0, 8'h00);
    req = 8'h00;

    // Single request from ptr=1, leaves ptr=3.
    push(8'h04, 3'd5, 2, 1'b0, 1'b1);
    req = 8'h04;
    serve(2, 0, 8'h00);
    req = 8'h00;

    // ptr=3 favours bit 3 over bit 0; owner then drops its request.
    push(8'h08, 3'd4, 3, 1'b0, 1'b1);
    push(8'h01, 3'd7, 1, 1'b0, 1'b1);
    req = 8'h09;
    serve(3, 1, 8'h08);
    serve(1, 0, 8'h00);
    req = 8'h00;

    // Async reset while bit 1 is granted.
    push(8'h02, 3'd6, 0, 1'b0, 1'b0);
    req = 8'h02;
    wait_grant(ok);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_grant", 32'(grant), 32'h0);
    check("midreset_idx", 32'(grant_idx), 32'h0);
    check("midreset_valid", 32'(grant_valid), 32'h0);
    check("midreset_timeout", 32'(timeout), 32'h0);

    // After reset ptr=0: bit 0 stuck -> timeout, then bit 5 releases on the limit cycle.
    push(8'h01, 3'd7, 4, 1'b1, 1'b1);
    push(8'h20, 3'd2, 4, 1'b0, 1'b1);
    req = 8'h21;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    serve(0, 2, 8'h00);
    serve(4, 0, 8'h00);
    req = 8'h00;

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
